// File: rtl/result_chk_pkg.sv
// Shared types and helpers for the result_checker self-check monitor.
// The record width constants bound the DATA_W / IW the checker is built with.
package result_chk_pkg;

    localparam int CHK_DATA_W = 32;
    localparam int CHK_IDX_W  = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } chk_state_e;

    typedef struct packed {
        logic [CHK_IDX_W-1:0]  idx;
        logic [CHK_DATA_W-1:0] got;
        logic [CHK_DATA_W-1:0] exp;
    } mis_rec_t;

    function automatic logic [CHK_DATA_W-1:0] merge_bytes(
        input logic [CHK_DATA_W-1:0]   old,
        input logic [CHK_DATA_W-1:0]   data,
        input logic [CHK_DATA_W/8-1:0] strb
    );
        logic [CHK_DATA_W-1:0] res;
        res = old;
        for (int b = 0; b < CHK_DATA_W/8; b++)
            if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
        return res;
    endfunction

endpackage

// File: rtl/result_window.sv
// Shadow (snooped, byte-merged) and golden word arrays with one shared read index.
// Golden storage has no reset so preloaded values survive rst.
module result_window
    import result_chk_pkg::*;
#(
    parameter int WIN_DEPTH = 64,
    parameter int DATA_W    = 32,
    parameter int IW        = $clog2(WIN_DEPTH+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [IW-1:0]     wr_idx,
    input  logic [DATA_W/8-1:0] wr_strb,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              gold_we,
    input  logic [IW-1:0]     gold_addr,
    input  logic [DATA_W-1:0] gold_data,
    input  logic [IW-1:0]     rd_idx,
    output logic [DATA_W-1:0] rd_shadow,
    output logic [DATA_W-1:0] rd_gold
);
    localparam int AW = (WIN_DEPTH > 1) ? $clog2(WIN_DEPTH) : 1;

    logic [DATA_W-1:0] shadow [WIN_DEPTH];
    logic [DATA_W-1:0] gold   [WIN_DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIN_DEPTH; i++) shadow[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < WIN_DEPTH; i++) shadow[i] <= '0;
        end else if (wr_en && (wr_idx < IW'(WIN_DEPTH))) begin
            shadow[wr_idx[AW-1:0]] <= merge_bytes(shadow[wr_idx[AW-1:0]], wr_data, wr_strb);
        end
    end

    always_ff @(posedge clk) begin
        if (gold_we && (gold_addr < IW'(WIN_DEPTH)))
            gold[gold_addr[AW-1:0]] <= gold_data;
    end

    assign rd_shadow = (rd_idx < IW'(WIN_DEPTH)) ? shadow[rd_idx[AW-1:0]] : '0;
    assign rd_gold   = (rd_idx < IW'(WIN_DEPTH)) ? gold[rd_idx[AW-1:0]]   : '0;

endmodule

// File: rtl/result_checker.sv
// On-chip end-of-test monitor: snoops DM writes into a shadow window, waits for the
// sentinel or cycle budget, then streams shadow/golden mismatches and reports pass/fail.
module result_checker
    import result_chk_pkg::*;
#(
    parameter int              ADDR_W     = 14,
    parameter int              DATA_W     = 32,
    parameter int              WIN_BASE   = 'h2000,
    parameter int              WIN_DEPTH  = 64,
    parameter int              END_ADDR   = 'h3fff,
    parameter logic [DATA_W-1:0] END_CODE = {DATA_W{1'b1}},
    parameter int              MAX_CYCLES = 100000,
    parameter int              IW         = $clog2(WIN_DEPTH+1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W/8-1:0] wr_strb,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                gold_we,
    input  logic [IW-1:0]       gold_addr,
    input  logic [DATA_W-1:0]   gold_data,
    input  logic [IW-1:0]       gold_num,
    output logic                mis_valid,
    input  logic                mis_ready,
    output logic [IW-1:0]       mis_idx,
    output logic [DATA_W-1:0]   mis_got,
    output logic [DATA_W-1:0]   mis_exp,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                timeout,
    output logic [IW-1:0]       err_cnt,
    output logic [63:0]         cycle_cnt
);
    localparam logic [ADDR_W:0]   WIN_LO   = (ADDR_W+1)'(WIN_BASE);
    localparam logic [ADDR_W:0]   WIN_HI   = (ADDR_W+1)'(WIN_BASE + WIN_DEPTH);
    localparam logic [ADDR_W-1:0] END_A    = ADDR_W'(END_ADDR);
    localparam logic [63:0]       LAST_CYC = 64'(MAX_CYCLES - 1);

    chk_state_e        state, state_nxt;
    logic [DATA_W-1:0] sent_q, sent_merged, shadow_rd, gold_rd;
    logic [IW-1:0]     idx_q, num, win_off, err_q;
    logic [63:0]       cyc_q;
    logic              to_q, mis_vld_q;
    mis_rec_t          mis_q;
    logic              in_win, win_we, gold_ok, sent_wr, sent_hit, expire;
    logic              cmp_ok, chk_adv, chk_last;

    assign in_win      = ({1'b0, wr_addr} >= WIN_LO) && ({1'b0, wr_addr} < WIN_HI);
    assign win_off     = IW'(wr_addr - WIN_LO[ADDR_W-1:0]);
    assign win_we      = (state == RUN) && wr_en && in_win;
    assign gold_ok     = gold_we && ((state == IDLE) || (state == DONE));
    assign sent_wr     = (state == RUN) && wr_en && (wr_addr == END_A);
    // Sentinel compare uses the merged value so a byte-wise sentinel fires on its last store.
    assign sent_merged = merge_bytes(sent_q, wr_data, wr_strb);
    assign sent_hit    = sent_wr && (sent_merged == END_CODE);
    assign expire      = (state == RUN) && (cyc_q == LAST_CYC);
    assign num         = (gold_num > IW'(WIN_DEPTH)) ? IW'(WIN_DEPTH) : gold_num;

    result_window #(.WIN_DEPTH(WIN_DEPTH), .DATA_W(DATA_W), .IW(IW)) u_win (
        .clk       (clk),
        .rst       (rst),
        .clr       (start),
        .wr_en     (win_we),
        .wr_idx    (win_off),
        .wr_strb   (wr_strb),
        .wr_data   (wr_data),
        .gold_we   (gold_ok),
        .gold_addr (gold_addr),
        .gold_data (gold_data),
        .rd_idx    (idx_q),
        .rd_shadow (shadow_rd),
        .rd_gold   (gold_rd)
    );

    // A held mismatch record advances only on acceptance; otherwise a match advances.
    assign cmp_ok   = (shadow_rd == gold_rd);
    assign chk_adv  = mis_vld_q ? mis_ready : ((idx_q < num) && cmp_ok);
    assign chk_last = (idx_q >= num) || (chk_adv && ((idx_q + IW'(1)) == num));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = RUN;
        end else begin
            case (state)
                RUN:     if (sent_hit || expire) state_nxt = CHECK;
                CHECK:   if (chk_last) state_nxt = DONE;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        busy = (state == RUN) || (state == CHECK);
        done = (state == DONE);
        pass = done && (err_q == '0) && !to_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sent_q    <= '0;
            cyc_q     <= '0;
            to_q      <= 1'b0;
            err_q     <= '0;
            idx_q     <= '0;
            mis_vld_q <= 1'b0;
            mis_q     <= '0;
        end else if (start) begin
            sent_q    <= '0;
            cyc_q     <= '0;
            to_q      <= 1'b0;
            err_q     <= '0;
            idx_q     <= '0;
            mis_vld_q <= 1'b0;
            mis_q     <= '0;
        end else begin
            if (state == RUN) begin
                cyc_q <= cyc_q + 64'd1;
                if (sent_wr) sent_q <= sent_merged;
                if (expire && !sent_hit) to_q <= 1'b1;
            end
            if (state == CHECK) begin
                if (mis_vld_q) begin
                    if (mis_ready) begin
                        mis_vld_q <= 1'b0;
                        err_q     <= err_q + IW'(1);
                        idx_q     <= idx_q + IW'(1);
                    end
                end else if (idx_q < num) begin
                    if (cmp_ok) begin
                        idx_q <= idx_q + IW'(1);
                    end else begin
                        mis_vld_q <= 1'b1;
                        mis_q.idx <= idx_q;
                        mis_q.got <= shadow_rd;
                        mis_q.exp <= gold_rd;
                    end
                end
            end
        end
    end

    assign mis_valid = mis_vld_q;
    assign mis_idx   = mis_q.idx;
    assign mis_got   = mis_q.got;
    assign mis_exp   = mis_q.exp;
    assign timeout   = to_q;
    assign err_cnt   = err_q;
    assign cycle_cnt = cyc_q;

endmodule

// File: tb/tb_result_checker.sv
// Directed + randomized bench for result_checker against a word-array reference model.
module tb_result_checker;
    localparam int ADDR_W    = 14;
    localparam int DATA_W    = 32;
    localparam int WIN_BASE  = 'h2000;
    localparam int WIN_DEPTH = 64;
    localparam int END_ADDR  = 'h3fff;
    localparam int MAX_CYC   = 50;
    localparam int IW        = $clog2(WIN_DEPTH+1);
    localparam logic [31:0] END_CODE = 32'hFFFF_FFFF;

    logic clk, rst, start, wr_en, gold_we, mis_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [3:0]        wr_strb;
    logic [31:0]       wr_data, gold_data, mis_got, mis_exp;
    logic [IW-1:0]     gold_addr, gold_num, mis_idx, err_cnt;
    logic              mis_valid, busy, done, pass, timeout;
    logic [63:0]       cycle_cnt;

    result_checker #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WIN_BASE(WIN_BASE), .WIN_DEPTH(WIN_DEPTH),
        .END_ADDR(END_ADDR), .END_CODE(END_CODE), .MAX_CYCLES(MAX_CYC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_strb(wr_strb), .wr_data(wr_data), .gold_we(gold_we), .gold_addr(gold_addr),
        .gold_data(gold_data), .gold_num(gold_num), .mis_valid(mis_valid),
        .mis_ready(mis_ready), .mis_idx(mis_idx), .mis_got(mis_got), .mis_exp(mis_exp),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_cnt(err_cnt),
        .cycle_cnt(cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] sh_m [WIN_DEPTH];
    logic [31:0] gd_m [WIN_DEPTH];
    logic [31:0] sent_m;
    int          run_cyc;
    bit          m_run, m_to;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d,
                                           input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~m) | (d & m);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock of RUN-phase stimulus; the model follows the written rules directly.
    task automatic cyc(input bit we, input int addr, input logic [3:0] strb, input logic [31:0] data);
        wr_en = we; wr_addr = ADDR_W'(addr); wr_strb = strb; wr_data = data;
        tick();
        wr_en = 1'b0;
        if (m_run) begin
            run_cyc++;
            if (we && addr >= WIN_BASE && addr < WIN_BASE + WIN_DEPTH)
                sh_m[addr - WIN_BASE] = bmerge(sh_m[addr - WIN_BASE], data, strb);
            if (we && addr == END_ADDR) begin
                sent_m = bmerge(sent_m, data, strb);
                if (sent_m == END_CODE) m_run = 0;
            end
            if (m_run && run_cyc == MAX_CYC) begin
                m_to = 1;
                m_run = 0;
            end
        end
    endtask

    task automatic load_gold(input int n);
        for (int i = 0; i < n; i++) begin
            gold_we = 1'b1; gold_addr = IW'(i); gold_data = gd_m[i];
            tick();
        end
        gold_we = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < WIN_DEPTH; i++) sh_m[i] = '0;
        sent_m = '0; run_cyc = 0; m_run = 1; m_to = 0;
    endtask

    task automatic write_1to4();
        for (int i = 0; i < 4; i++) cyc(1, WIN_BASE + i, 4'hF, 32'(i + 1));
    endtask

    task automatic gold_1to4();
        for (int i = 0; i < 4; i++) gd_m[i] = 32'(i + 1);
        load_gold(4);
    endtask

    // Drain CHECK: compare every record, apply ready back-pressure, verify latency and verdict.
    task automatic check_phase(input string tag, input int hold);
        int num, nmis, low, n, hl;
        bit r, acc;
        int qi[$];
        logic [31:0] qg[$];
        logic [31:0] qe[$];
        num = (int'(gold_num) > WIN_DEPTH) ? WIN_DEPTH : int'(gold_num);
        for (int i = 0; i < num; i++)
            if (sh_m[i] !== gd_m[i]) begin
                qi.push_back(i); qg.push_back(sh_m[i]); qe.push_back(gd_m[i]);
            end
        nmis = qi.size(); low = 0; n = 0; hl = hold;
        while (!done && n < 1000) begin
            acc = 0;
            r = 1'($urandom_range(0, 1));
            if (mis_valid) begin
                if (qi.size() == 0) chk({tag, "_extra_rec"}, 64'(mis_valid), 64'd0);
                else begin
                    chk({tag, "_mis_idx"}, 64'(mis_idx), 64'(qi[0]));
                    chk({tag, "_mis_got"}, 64'(mis_got), 64'(qg[0]));
                    chk({tag, "_mis_exp"}, 64'(mis_exp), 64'(qe[0]));
                    if (hold >= 0) r = (hl == 0);
                    if (r) begin
                        acc = 1;
                        void'(qi.pop_front()); void'(qg.pop_front()); void'(qe.pop_front());
                        hl = hold;
                    end else begin
                        low++;
                        if (hl > 0) hl--;
                    end
                end
            end
            mis_ready = r;
            tick();
            n++;
            if (acc) chk({tag, "_vld_drop"}, 64'(mis_valid), 64'd0);
        end
        mis_ready = 1'b0;
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_latency"}, 64'(n), 64'(((num > 1) ? num : 1) + nmis + low));
        chk({tag, "_recs_left"}, 64'(qi.size()), 64'd0);
        chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(nmis));
        chk({tag, "_pass"}, 64'(pass), 64'((nmis == 0) && !m_to));
        chk({tag, "_timeout"}, 64'(timeout), 64'(m_to));
        chk({tag, "_cycle_cnt"}, cycle_cnt, 64'(run_cyc));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_mis_valid"}, 64'(mis_valid), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mis_valid"}, 64'(mis_valid), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_pass"}, 64'(pass), 64'd0);
        chk({tag, "_timeout"}, 64'(timeout), 64'd0);
        chk({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
        chk({tag, "_cycle_cnt"}, cycle_cnt, 64'd0);
        chk({tag, "_mis_idx"}, 64'(mis_idx), 64'd0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_strb = '0; wr_data = '0;
        gold_we = 1'b0; gold_addr = '0; gold_data = '0; gold_num = '0; mis_ready = 1'b0;
        m_run = 0; m_to = 0; run_cyc = 0; sent_m = '0;
        #2 rst = 1'b1;
        #2 check_all_zero("reset");
        tick(); tick();
        @(negedge clk) rst = 1'b0;
        tick();

        // Clean pass
        gold_num = IW'(4);
        gold_1to4();
        do_start();
        write_1to4();
        cyc(1, END_ADDR, 4'hF, END_CODE);
        check_phase("clean", 0);

        // Single mismatch with 3 cycles of back-pressure
        do_start();
        cyc(1, WIN_BASE + 0, 4'hF, 32'd1);
        cyc(1, WIN_BASE + 1, 4'hF, 32'd2);
        cyc(1, WIN_BASE + 2, 4'hF, 32'd9);
        cyc(1, WIN_BASE + 3, 4'hF, 32'd4);
        cyc(1, END_ADDR, 4'hF, END_CODE);
        check_phase("mis1", 3);

        // Restart from DONE clears counters; sentinel arrives as four byte stores
        do_start();
        chk("restart_err_cnt", 64'(err_cnt), 64'd0);
        chk("restart_busy", 64'(busy), 64'd1);
        chk("restart_done", 64'(done), 64'd0);
        write_1to4();
        for (int b = 0; b < 3; b++) begin
            cyc(1, END_ADDR, 4'(1 << b), 32'hFFFF_FFFF);
            chk("bytesent_done", 64'(done), 64'd0);
            chk("bytesent_cyc", cycle_cnt, 64'(run_cyc));
        end
        cyc(1, END_ADDR, 4'b1000, 32'hFFFF_FFFF);
        check_phase("bytesent", 0);

        // Byte merge into shadow[0]; writes just outside the window are ignored
        gd_m[0] = 32'hAABB_11DD;
        load_gold(1);
        do_start();
        cyc(1, WIN_BASE, 4'hF, 32'hAABB_CCDD);
        cyc(1, WIN_BASE, 4'b0010, 32'h0000_1100);
        cyc(1, WIN_BASE + WIN_DEPTH, 4'hF, 32'h1234_5678);
        cyc(1, WIN_BASE - 1, 4'hF, 32'h8765_4321);
        for (int i = 1; i < 4; i++) cyc(1, WIN_BASE + i, 4'hF, 32'(i + 1));
        cyc(1, END_ADDR, 4'hF, END_CODE);
        check_phase("merge", -1);

        // Budget expiry with all-matching data
        gold_1to4();
        do_start();
        write_1to4();
        for (int k = 0; k < 100 && m_run; k++) cyc(0, 0, 4'h0, 32'h0);
        chk("tmo_model_cyc", 64'(cycle_cnt), 64'd50);
        check_phase("timeout", 0);

        // Sentinel on the expiry edge wins
        do_start();
        chk("restart_timeout", 64'(timeout), 64'd0);
        chk("restart_cycle_cnt", cycle_cnt, 64'd0);
        write_1to4();
        for (int k = 0; k < MAX_CYC - 5; k++) cyc(0, 0, 4'h0, 32'h0);
        cyc(1, END_ADDR, 4'hF, END_CODE);
        check_phase("coincide", 0);

        // Empty golden set
        gold_num = '0;
        do_start();
        cyc(1, END_ADDR, 4'hF, END_CODE);
        check_phase("num0", -1);

        // Random window contents, clamped gold_num, gold writes during RUN ignored
        for (int i = 0; i < WIN_DEPTH; i++)
            gd_m[i] = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
        load_gold(WIN_DEPTH);
        gold_num = IW'(70);
        do_start();
        for (int k = 0; k < 30; k++) begin
            int a;
            a = WIN_BASE + int'($urandom_range(0, WIN_DEPTH - 1));
            if (k == 5) begin gold_we = 1'b1; gold_addr = '0; gold_data = 32'hDEAD_BEEF; end
            if ($urandom_range(0, 1) == 1) cyc(1, a, 4'hF, gd_m[a - WIN_BASE]);
            else cyc(1, a, 4'($urandom_range(1, 15)), $urandom);
            gold_we = 1'b0;
        end
        cyc(1, END_ADDR, 4'hF, END_CODE);
        check_phase("random", -1);

        // Reset in the middle of CHECK
        gold_num = IW'(4);
        gold_1to4();
        do_start();
        cyc(1, WIN_BASE, 4'hF, 32'd9);
        cyc(1, END_ADDR, 4'hF, END_CODE);
        for (int k = 0; k < 10 && !mis_valid; k++) tick();
        chk("midchk_mis_valid", 64'(mis_valid), 64'd1);
        #1 rst = 1'b1;
        #1 check_all_zero("midchk_rst");
        @(negedge clk) rst = 1'b0;
        tick();

        // Golden storage survives reset
        do_start();
        write_1to4();
        cyc(1, END_ADDR, 4'hF, END_CODE);
        check_phase("post_rst", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_checker.md
# result_checker

Synthesizable on-chip self-check monitor for CPU program tests. It snoops the data-memory write port and keeps a byte-merged shadow of a result window. It detects the end-of-test sentinel write, or a cycle-budget timeout, then compares the window word-by-word against preloaded golden values. Each mismatch is streamed out, and the block reports pass/fail, error count and total cycle count. It sits beside `top` and generalises the simulation-only end/compare flow with parametrised addresses, depth and budget, byte-strobe merging, and a handshaked mismatch stream.

## Interface
- ADDR_W, 14: DM word-address width
- DATA_W, 32: data width; must be a multiple of 8
- WIN_BASE, 'h2000: first word address of the result window
- WIN_DEPTH, 64: number of window/golden words
- END_ADDR, 'h3fff: sentinel word address; must lie outside the window
- END_CODE, 32'hFFFF_FFFF: sentinel value
- MAX_CYCLES, 100000: cycle budget in RUN
- IW = $clog2(WIN_DEPTH+1): derived index width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  pulse: clear shadow, counters and flags; enter RUN
- wr_en  in  1  DM write strobe
- wr_addr  in  ADDR_W  DM word address
- wr_strb  in  DATA_W/8  byte enables
- wr_data  in  DATA_W  write data
- gold_we  in  1  golden load strobe; honoured only in IDLE/DONE
- gold_addr  in  IW  golden index
- gold_data  in  DATA_W  golden word
- gold_num  in  IW  valid golden count; clamped to WIN_DEPTH
- mis_valid  out  1  mismatch record valid
- mis_ready  in  1  consumer accepts record
- mis_idx  out  IW  mismatching window index
- mis_got  out  DATA_W  shadow value
- mis_exp  out  DATA_W  golden value
- busy  out  1  state is RUN or CHECK
- done  out  1  state is DONE
- pass  out  1  valid when done
- timeout  out  1  budget expired
- err_cnt  out  IW  mismatches found
- cycle_cnt  out  64  cycles spent in RUN

## Operation
- States: IDLE, RUN, CHECK, DONE. Reset enters IDLE; every output is 0, shadow and sentinel registers are 0, golden storage is unchanged.
- start in any state:
  - clears shadow, sentinel register, err_cnt, cycle_cnt, timeout and the check index
  - next state is RUN
  - aborts any pending mismatch record
- RUN:
  - cycle_cnt increments every cycle.
  - A write with wr_addr in [WIN_BASE, WIN_BASE+WIN_DEPTH) merges the strobed bytes into shadow[wr_addr-WIN_BASE].
  - A write to END_ADDR merges the strobed bytes into the sentinel register.
  - If the merged sentinel value (the value being written this cycle) equals END_CODE, go to CHECK.
  - Otherwise, if cycle_cnt reaches MAX_CYCLES-1 on this edge, set timeout=1 and go to CHECK.
  - If the sentinel write and the budget expiry coincide, the sentinel wins and timeout stays 0.
- CHECK:
  - Compare shadow[idx] against gold[idx], starting at idx=0.
  - Match: idx increments.
  - Mismatch: mis_valid=1 with record fields; hold until mis_ready; on the accept edge err_cnt++ and idx++.
  - After the last index, go to DONE. With gold_num=0, go to DONE on the first CHECK edge.
  - DM writes are ignored in CHECK and DONE.
- DONE: pass = (err_cnt==0) && !timeout. Outputs hold until start or rst.
- rst at any point, including mid-CHECK, returns to IDLE immediately.

## Timing
- Snoop writes take effect on the sampling edge. The merge is combinational, so a sentinel delivered as byte stores is detected on the edge of the completing store.
- Sentinel sampled at edge E: busy stays high, CHECK starts after E, index 0 is compared in cycle E+1.
- With no mismatches, done rises after edge E+max(gold_num,1).
- Each mismatch adds at least one cycle, plus one cycle per cycle mis_ready is held low.
- mis_* outputs are registered, stable while mis_valid=1 and !mis_ready, and deasserted the cycle after acceptance.
- cycle_cnt counts RUN cycles, including the sentinel edge, and then freezes.

## Structure
- Package result_chk_pkg holds:
  - state enum chk_state_e
  - function merge_bytes(old, data, strb)
  - struct mis_rec_t {idx, got, exp}
- Sub-module result_window (parametrised by WIN_DEPTH, DATA_W):
  - shadow and golden register arrays
  - byte-merge write port
  - golden load port
  - single read index
- The top-level result_checker holds the FSM, the counters and the mismatch output register.

## Test plan
- Load gold[0..3] = 1,2,3,4 with gold_num=4; start; full-word writes of 1..4 to 'h2000..'h2003, then a write of FFFF_FFFF to 'h3fff -> done after 4 CHECK cycles, pass=1, err_cnt=0, no mis_valid.
- Same setup, but write 9 to 'h2002 -> one record {idx=2, got=9, exp=3}; hold mis_ready=0 for 3 cycles: record stable, done delayed by 3 cycles; final err_cnt=1, pass=0.
- Sentinel written as four single-byte stores to 'h3fff (strb 0001..1000, byte FF each) -> CHECK is entered only on the fourth store's edge.
- Byte-merge: write AABBCCDD, then strb=0010 data 0000_1100 to 'h2000 -> shadow[0]=AABB11DD, compared against gold.
- With MAX_CYCLES=50 and no sentinel -> timeout=1 after 50 RUN cycles, cycle_cnt=50, pass=0 even with all-matching data; sentinel and expiry on the same edge -> timeout=0.
- Boundary and reset cases:
  - gold_num=0 -> done one cycle after the sentinel, pass=1.
  - A write to WIN_BASE+WIN_DEPTH is ignored.
  - rst asserted mid-CHECK -> all outputs 0 asynchronously.
  - start in DONE -> returns to RUN with cleared counters.
